// File: rtl/timer_dev.sv
// Countdown timer responder on the CPU data bus.
// Ports: clk, reset, addr/we/din (bus write), dout (read), irq.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        flag_q;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        set_flag;
  logic        clr_flag;
  logic        clr_en;

  always_comb begin
    wr_ctrl   = 1'b0;
    wr_preset = 1'b0;
    unique case (1'b1)
      (we && addr == 2'd0): wr_ctrl   = 1'b1;
      (we && addr == 2'd1): wr_preset = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    set_flag = 1'b0;
    clr_flag = 1'b0;
    clr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_q) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // 0 and 1 both expire, so PRESET=0 acts as 1
          count_d  = '0;
          set_flag = 1'b1;
          state_d  = INT;
        end
      end
      INT: begin
        if (mode_q == 2'b01) begin
          clr_flag = 1'b1;
          state_d  = LOAD;
        end else begin
          clr_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_ctrl) begin
        // bus write beats the one-shot EN clear
        en_q   <= din[0];
        mode_q <= din[2:1];
        im_q   <= din[3];
      end else if (clr_en) begin
        en_q <= 1'b0;
      end
      if (wr_preset) preset_q <= din;
      // expiry beats any clear so no interrupt is lost
      if (set_flag)
        flag_q <= 1'b1;
      else if (clr_flag || wr_ctrl || wr_preset)
        flag_q <= 1'b0;
    end
  end

  always_comb begin
    dout = '0;
    unique case (addr)
      2'd0: dout = {28'd0, im_q, mode_q, en_q};
      2'd1: dout = preset_q;
      2'd2: dout = count_q;
      2'd3: dout = '0;
      default: dout = '0;
    endcase
  end

  assign irq = flag_q & im_q;

endmodule
